board_debug_ctrl: RTL

Board-level debug front end for the CPU bring-up boards.
- Debounces the raw step button and generates the CPU clock, either one pulse per press (STEP mode) or free-running from a divider (RUN mode).
- Selects one of NUM_CH debug channels and scans it as hex onto a DIGITS-digit multiplexed seven-segment display.
- Sits between the board pins and the CPU core, replacing the separate debounce, clock-toggle, display-mux and scan-divider logic.

---
 rtl/board_debug_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/board_debug_ctrl.sv
// board_debug_ctrl
//   Debug front end for the CPU bring-up boards: debounces the step button,
//   generates the CPU clock (one pulse per press in STEP mode, free-running in
//   RUN mode) and scans a selected debug channel as hex onto a multiplexed
//   seven-segment display.
//
//   Optional build macro BOARD_DBG_LATCH_EN: when defined, the display reads a
//   snapshot of ch_data captured on every accepted step_pulse instead of the
//   live channel data.
//
// Ports
//   CLK         system clock
//   Reset       asynchronous active-low reset
//   step_btn    raw step button (active-high), asynchronous
//   mode_run    1 = RUN, 0 = STEP, asynchronous
//   sel         debug channel select, asynchronous
//   ch_data     NUM_CH packed channels, channel k at [k*DATA_W +: DATA_W]
//   step_pulse  one-cycle pulse per accepted CPU step
//   cpu_clk     CPU clock, high CLK_HIGH cycles per accepted step
//   btn_level   debounced button level
//   pos_ctrl    digit enables, active-low one-hot
//   num_ctrl    segments, active-low, [7] = dp, [6:0] = g..a
module board_debug_ctrl #(
  parameter  int NUM_CH   = 4,
  parameter  int DATA_W   = 16,
  parameter  int DIGITS   = 4,
  parameter  int DEB_CNT  = 1000000,
  parameter  int SCAN_DIV = 250000,
  parameter  int RUN_DIV  = 5000000,
  parameter  int CLK_HIGH = 2,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     step_btn,
  input  logic                     mode_run,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     step_pulse,
  output logic                     cpu_clk,
  output logic                     btn_level,
  output logic [DIGITS-1:0]        pos_ctrl,
  output logic [7:0]               num_ctrl
);

  localparam int DEB_W  = $clog2(DEB_CNT + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int RUN_W  = $clog2(RUN_DIV + 1);
  localparam int HIGH_W = $clog2(CLK_HIGH + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DISP_W = DIGITS * 4;
  localparam int EXT_W  = (DATA_W > DISP_W) ? DATA_W : DISP_W;

  // Hex digit to active-low g..a segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic              btn_sync_p0, btn_sync_p1;
  logic              mode_sync_p0, mode_sync_p1;
  logic [SEL_W-1:0]  sel_sync_p0, sel_sync_p1;
  logic [DEB_W-1:0]  deb_cnt;
  logic              btn_level_prev;
  logic              mode_prev;
  logic [RUN_W-1:0]  run_cnt;
  logic [HIGH_W-1:0] high_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic              run_req;
  logic              step_req;
  logic              step_accept;
  logic [NUM_CH*DATA_W-1:0] disp_src;
  logic [DATA_W-1:0] chan;
  logic [EXT_W-1:0]  chan_ext;
  logic [DISP_W-1:0] disp_val;
  logic [3:0]        nibble;

  // Stage p0/p1: two-flop synchronisers for all asynchronous board inputs
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      btn_sync_p0  <= 1'b0;
      btn_sync_p1  <= 1'b0;
      mode_sync_p0 <= 1'b0;
      mode_sync_p1 <= 1'b0;
      sel_sync_p0  <= '0;
      sel_sync_p1  <= '0;
    end else begin
      btn_sync_p0  <= step_btn;
      btn_sync_p1  <= btn_sync_p0;
      mode_sync_p0 <= mode_run;
      mode_sync_p1 <= mode_sync_p0;
      sel_sync_p0  <= sel;
      sel_sync_p1  <= sel_sync_p0;
    end
  end

  // Debouncer: the count only survives while the input keeps disagreeing
  // with the current level, so any return to the old level restarts it.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      deb_cnt        <= '0;
      btn_level      <= 1'b0;
      btn_level_prev <= 1'b0;
    end else begin
      btn_level_prev <= btn_level;
      if (btn_sync_p1 == btn_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
        deb_cnt   <= '0;
        btn_level <= btn_sync_p1;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // RUN divider, restarted on every change of the synchronised mode
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mode_prev <= 1'b0;
      run_cnt   <= '0;
    end else begin
      mode_prev <= mode_sync_p1;
      if (mode_sync_p1 != mode_prev || !mode_sync_p1) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_W'(RUN_DIV - 1)) begin
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

  assign run_req  = mode_sync_p1 && (mode_sync_p1 == mode_prev) &&
                    (run_cnt == RUN_W'(RUN_DIV - 1));
  assign step_req = mode_sync_p1 ? run_req : (btn_level & ~btn_level_prev);

  // Requests landing while the high counter is busy (or on the pulse cycle
  // itself, before the counter has been loaded) are dropped.
  assign step_accept = step_req && (high_cnt == '0) && !step_pulse;

  // Stage p2: step pulse, then cpu_clk held high for CLK_HIGH cycles
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      step_pulse <= 1'b0;
      cpu_clk    <= 1'b0;
      high_cnt   <= '0;
    end else begin
      step_pulse <= step_accept;
      if (step_pulse) begin
        high_cnt <= HIGH_W'(CLK_HIGH);
        cpu_clk  <= 1'b1;
      end else if (high_cnt != '0) begin
        high_cnt <= high_cnt - HIGH_W'(1);
        cpu_clk  <= (high_cnt > HIGH_W'(1));
      end
    end
  end

`ifdef BOARD_DBG_LATCH_EN
  logic [NUM_CH*DATA_W-1:0] snap_p0;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      snap_p0 <= '0;
    end else if (step_pulse) begin
      snap_p0 <= ch_data;
    end
  end

  assign disp_src = snap_p0;
`else
  assign disp_src = ch_data;
`endif

  // Channel mux; an out-of-range select leaves the value at zero.
  always_comb begin
    chan = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_sync_p1 == SEL_W'(k)) chan = disp_src[k*DATA_W +: DATA_W];
    end
  end

  assign chan_ext = EXT_W'(chan);
  assign disp_val = chan_ext[DISP_W-1:0];

  always_comb begin
    nibble = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_idx == IDX_W'(d)) nibble = disp_val[d*4 +: 4];
    end
  end

  // Scanner and registered display pins
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      pos_ctrl  <= '1;
      num_ctrl  <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      pos_ctrl <= ~(DIGITS'(1) << digit_idx);
      num_ctrl <= {~(mode_sync_p1 && (digit_idx == '0)), hex_to_seg(nibble)};
    end
  end

endmodule
